// File: rtl/mem_lsu_if.sv
// Data-bus interface between the MEM-stage load/store unit and the data memory.
//   master (LSU)   : drives bus_req, bus_we, bus_addr, bus_be, bus_wdata
//                    samples bus_ack, bus_rdata
//   slave (memory) : the mirror image
// bus_addr is always word aligned; bus_be lane n covers bits 8n+7:8n.
interface mem_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Issues lw/lh/lhu/lb/lbu/sw/sh/sb over a req/ack
// bus, extends load data into dm_out, stalls the pipeline while an access is
// outstanding and flags misaligned accesses without touching the bus.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   int_clr       synchronous MEM-stage flush
//   op_valid      MEM stage holds a load/store
//   op_type       000 lw 001 lh 010 lhu 011 lb 100 lbu 101 sw 110 sh 111 sb
//   addr, wdata   effective byte address, store data
//   stall         pipeline freeze (combinational)
//   dm_out        extended load result (registered)
//   addr_exc      misaligned access this cycle (combinational)
//   bus_err       one-cycle timeout pulse (registered)
//   bus           mem_lsu_if master: registered req/we/addr/be/wdata, ack/rdata in
//
// Optional build macro LSU_TIMEOUT_EN: bounds each REQ/DRAIN wait to TIMEOUT
// cycles and reports expiry on bus_err. Without it the unit waits for ack
// indefinitely and bus_err is constant 0.
module mem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             int_clr,
  input  logic             op_valid,
  input  logic [2:0]       op_type,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             stall,
  output logic [31:0]      dm_out,
  output logic             addr_exc,
  output logic             bus_err,
  mem_lsu_if.master        bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned BEW = 4;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q;
  logic [DW-1:0]    bus_addr_q;
  logic [BEW-1:0]   bus_be_q;
  logic [DW-1:0]    bus_wdata_q;
  logic [DW-1:0]    dm_out_q, dm_out_d;
  logic             bus_err_q, bus_err_d;
  logic [2:0]       op_q;
  logic [1:0]       off_q;

  logic             is_word, is_half, is_store, misaligned;
  logic [BEW-1:0]   be_c;
  logic [DW-1:0]    wdata_c;
  logic             issue;
  logic             load_q;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [DW-1:0]    ld_data;
  logic             tmo;

  // Decode width/direction of the incoming op, alignment, lanes and store data.
  always_comb begin
    is_word    = (op_type == OP_LW) || (op_type == OP_SW);
    is_half    = (op_type == OP_LH) || (op_type == OP_LHU) || (op_type == OP_SH);
    is_store   = (op_type == OP_SW) || (op_type == OP_SH) || (op_type == OP_SB);
    misaligned = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);

    if (is_word) begin
      be_c = 4'b1111;
    end else if (is_half) begin
      be_c = addr[1] ? 4'b1100 : 4'b0011;
    end else begin
      be_c = 4'(4'b0001 << addr[1:0]);
    end

    if (is_word) begin
      wdata_c = wdata;
    end else if (is_half) begin
      wdata_c = {2{wdata[15:0]}};
    end else begin
      wdata_c = {4{wdata[7:0]}};
    end
  end

  // Extract and extend the lane(s) of read data chosen by the captured offset.
  always_comb begin
    load_q  = !((op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB));
    ld_byte = bus.bus_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (op_q)
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'h0000, ld_half};
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'h000000, ld_byte};
      default: ld_data = bus.bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Wait counter: cleared on entry to REQ/DRAIN, counts every cycle spent there.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q && (state_d == S_REQ || state_d == S_DRAIN)) begin
      cnt_d = 8'd0;
    end else if (state_q == S_REQ || state_q == S_DRAIN) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires in the TIMEOUT-th wait cycle when no ack has arrived.
  assign tmo = (cnt_q == TMO_LAST);
`else
  assign tmo = 1'b0;
`endif

  // Next state, stall/exception and the registered bus/result updates.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    addr_exc  = 1'b0;
    issue     = 1'b0;
    bus_req_d = bus_req_q;
    dm_out_d  = dm_out_q;
    bus_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_exc = op_valid && misaligned;
        stall    = op_valid && !misaligned;
        if (op_valid && !misaligned && !int_clr) begin
          state_d   = S_REQ;
          issue     = 1'b1;
          bus_req_d = 1'b1;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        // Ack wins over a simultaneous flush; the later flush is handled by MEM/WB.
        if (bus.bus_ack) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          if (load_q) begin
            dm_out_d = ld_data;
          end
        end else if (tmo) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (load_q) begin
            dm_out_d = '0;
          end
        end else if (int_clr) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        // Pipeline already flushed: finish the bus handshake, drop the data.
        if (bus.bus_ack) begin
          state_d   = S_IDLE;
          bus_req_d = 1'b0;
        end else if (tmo) begin
          state_d   = S_IDLE;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      dm_out_q    <= '0;
      bus_err_q   <= 1'b0;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      state_q   <= state_d;
      bus_req_q <= bus_req_d;
      dm_out_q  <= dm_out_d;
      bus_err_q <= bus_err_d;
      if (issue) begin
        bus_we_q    <= is_store;
        bus_addr_q  <= {addr[31:2], 2'b00};
        bus_be_q    <= be_c;
        bus_wdata_q <= wdata_c;
        op_q        <= op_type;
        off_q       <= addr[1:0];
      end
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign dm_out        = dm_out_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: the bench plays the data-memory slave and checks
// stall, dm_out, addr_exc, bus_err and the registered bus outputs.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_clr;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] dm_out;
  logic        addr_exc;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int stalls;

  mem_lsu_if bus_if ();

  mem_lsu #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .int_clr  (int_clr),
    .op_valid (op_valid),
    .op_type  (op_type),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .dm_out   (dm_out),
    .addr_exc (addr_exc),
    .bus_err  (bus_err),
    .bus      (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one access, let it wait `waits` REQ cycles, ack it, stop in DONE.
  // Returns the number of cycles stall was high.
  task automatic run_access(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int waits, output int n_stall);
    n_stall = 0;
    step();
    op_valid = 1'b1; op_type = op; addr = a; wdata = wd;
    #1;
    if (stall) n_stall++;
    step();
    for (int i = 0; i < waits; i++) begin
      if (stall) n_stall++;
      step();
    end
    if (stall) n_stall++;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rd;
    step();
    bus_if.bus_ack = 1'b0; op_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; int_clr = 1'b0; op_valid = 1'b0; op_type = 3'd0;
    addr = '0; wdata = '0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;

    // Reset values
    #12;
    chk("rst_stall",   32'(stall), 32'd0);
    chk("rst_dm_out",  dm_out, 32'd0);
    chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_bus_be",  32'(bus_if.bus_be), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // lb at 0x1003, ack in first REQ cycle
    step();
    op_valid = 1'b1; op_type = 3'd3; addr = 32'h0000_1003;
    #1;
    chk("lb_issue_stall", 32'(stall), 32'd1);
    chk("lb_issue_exc",   32'(addr_exc), 32'd0);
    chk("lb_issue_req",   32'(bus_if.bus_req), 32'd0);
    step();
    chk("lb_req",      32'(bus_if.bus_req), 32'd1);
    chk("lb_be",       32'(bus_if.bus_be), 32'h8);
    chk("lb_addr",     bus_if.bus_addr, 32'h0000_1000);
    chk("lb_we",       32'(bus_if.bus_we), 32'd0);
    chk("lb_req_stall", 32'(stall), 32'd1);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h80FF_1234;
    step();
    bus_if.bus_ack = 1'b0; op_valid = 1'b0;
    #1;
    chk("lb_done_stall", 32'(stall), 32'd0);
    chk("lb_done_req",   32'(bus_if.bus_req), 32'd0);
    chk("lb_dm_out",     dm_out, 32'hFFFF_FF80);

    // lbu, same setup
    run_access(3'd4, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, stalls);
    chk("lbu_stall_cycles", 32'(stalls), 32'd2);
    chk("lbu_dm_out", dm_out, 32'h0000_0080);

    // sh at 0x2002
    step();
    op_valid = 1'b1; op_type = 3'd6; addr = 32'h0000_2002; wdata = 32'hAAAA_BEEF;
    #1;
    chk("sh_issue_stall", 32'(stall), 32'd1);
    step();
    chk("sh_we",    32'(bus_if.bus_we), 32'd1);
    chk("sh_be",    32'(bus_if.bus_be), 32'hC);
    chk("sh_wdata", bus_if.bus_wdata, 32'hBEEF_BEEF);
    chk("sh_addr",  bus_if.bus_addr, 32'h0000_2000);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1111_1111;
    step();
    bus_if.bus_ack = 1'b0; op_valid = 1'b0;
    #1;
    chk("sh_dm_kept", dm_out, 32'h0000_0080);
    chk("sh_done_req", 32'(bus_if.bus_req), 32'd0);

    // Misaligned lw/lh, then an aligned sb held back by int_clr
    step();
    op_valid = 1'b1; op_type = 3'd0; addr = 32'h0000_3001;
    #1;
    chk("lw_mis_exc",   32'(addr_exc), 32'd1);
    chk("lw_mis_stall", 32'(stall), 32'd0);
    step();
    chk("lw_mis_noreq", 32'(bus_if.bus_req), 32'd0);
    op_type = 3'd1;
    #1;
    chk("lh_mis_exc", 32'(addr_exc), 32'd1);
    op_type = 3'd7; addr = 32'h0000_3003; int_clr = 1'b1;
    #1;
    chk("sb_odd_exc",   32'(addr_exc), 32'd0);
    chk("sb_odd_stall", 32'(stall), 32'd1);
    step();
    chk("sb_flushed_noreq", 32'(bus_if.bus_req), 32'd0);
    op_valid = 1'b0; int_clr = 1'b0;
    #1;
    chk("idle_exc_low", 32'(addr_exc), 32'd0);

    // lw with ack in the 4th REQ cycle
    run_access(3'd0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 3, stalls);
    chk("lw_wait_stall_cycles", 32'(stalls), 32'd5);
    chk("lw_wait_done_stall",   32'(stall), 32'd0);
    chk("lw_wait_dm_out",       dm_out, 32'hDEAD_BEEF);
    // Exactly one DONE cycle: next cycle is IDLE and accepts a new op
    step();
    op_valid = 1'b1; op_type = 3'd1; addr = 32'h0000_5002;
    #1;
    chk("after_done_idle_stall", 32'(stall), 32'd1);
    step();
    chk("lh_be", 32'(bus_if.bus_be), 32'hC);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h8001_7FFF;
    step();
    bus_if.bus_ack = 1'b0; op_valid = 1'b0;
    #1;
    chk("lh_dm_out", dm_out, 32'hFFFF_8001);

    // lhu lower half, one wait cycle
    run_access(3'd2, 32'h0000_5000, 32'h0, 32'h8001_F00F, 1, stalls);
    chk("lhu_stall_cycles", 32'(stalls), 32'd3);
    chk("lhu_dm_out", dm_out, 32'h0000_F00F);

    // Flush in 2nd REQ cycle, ack two cycles later in DRAIN
    step();
    op_valid = 1'b1; op_type = 3'd0; addr = 32'h0000_6000;
    step();
    chk("drain_req1", 32'(bus_if.bus_req), 32'd1);
    step();
    int_clr = 1'b1;
    #1;
    chk("drain_req2_stall", 32'(stall), 32'd1);
    step();
    int_clr = 1'b0; op_valid = 1'b0;
    #1;
    chk("drain1_stall", 32'(stall), 32'd0);
    chk("drain1_req",   32'(bus_if.bus_req), 32'd1);
    step();
    chk("drain2_req", 32'(bus_if.bus_req), 32'd1);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    step();
    bus_if.bus_ack = 1'b0;
    #1;
    chk("drain_end_req", 32'(bus_if.bus_req), 32'd0);
    chk("drain_dm_kept", dm_out, 32'h0000_F00F);
    op_valid = 1'b1; op_type = 3'd0; addr = 32'h0000_6004;
    #1;
    chk("drain_back_idle", 32'(stall), 32'd1);

    // ack and int_clr together in REQ: ack wins
    step();
    bus_if.bus_ack = 1'b1; int_clr = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
    step();
    bus_if.bus_ack = 1'b0; int_clr = 1'b0; op_valid = 1'b0;
    #1;
    chk("ackclr_dm_out", dm_out, 32'hCAFE_F00D);
    chk("ackclr_stall",  32'(stall), 32'd0);

    // Stray ack in IDLE is ignored
    step();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_if.bus_ack = 1'b0;
    #1;
    chk("stray_ack_req", 32'(bus_if.bus_req), 32'd0);
    chk("stray_ack_dm",  dm_out, 32'hCAFE_F00D);

`ifdef LSU_TIMEOUT_EN
    // Load with no ack: times out after 4 REQ cycles
    step();
    op_valid = 1'b1; op_type = 3'd0; addr = 32'h0000_8004;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tmo_req_held", 32'(bus_if.bus_req), 32'd1);
      chk("tmo_err_low",  32'(bus_err), 32'd0);
    end
    step();
    op_valid = 1'b0;
    #1;
    chk("tmo_req_drop", 32'(bus_if.bus_req), 32'd0);
    chk("tmo_err_pulse", 32'(bus_err), 32'd1);
    chk("tmo_dm_zero",  dm_out, 32'd0);
    chk("tmo_done_stall", 32'(stall), 32'd0);
    step();
    chk("tmo_err_one_cycle", 32'(bus_err), 32'd0);
`else
    chk("no_tmo_err", 32'(bus_err), 32'd0);
`endif

    // Asynchronous reset in the middle of REQ
    step();
    op_valid = 1'b1; op_type = 3'd0; addr = 32'h0000_7000;
    step();
    chk("arst_pre_req", 32'(bus_if.bus_req), 32'd1);
    op_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req",   32'(bus_if.bus_req), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_dm",    dm_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("arst_idle_req", 32'(bus_if.bus_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
